// File: rtl/cq_pkg.sv
// Shared sizing for the circular-queue controller, its storage array and its read mux.
package cq_pkg;

  localparam int CQ_DEPTH = 8;

  function automatic int cq_aw(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int cq_cw(input int depth);
    return cq_aw(depth) + 1;
  endfunction

endpackage

// File: rtl/cq_ptr.sv
// Queue pointer register that wraps at DEPTH-1, with synchronous reset, increment and load.
module cq_ptr
  import cq_pkg::*;
#(
  parameter int DEPTH = CQ_DEPTH,
  parameter int AW    = cq_aw(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          load,
  input  logic [AW-1:0] load_val,
  output logic [AW-1:0] ptr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  // Explicit compare against DEPTH-1 so non-power-of-2 depths never visit unused codes.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= load_val;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/cq_ctrl.sv
// Circular-queue sequencer: pointers, occupancy, full/empty, acceptance, entry load strobes, sticky errors.
module cq_ctrl
  import cq_pkg::*;
#(
  parameter  int DEPTH = CQ_DEPTH,
  localparam int AW    = cq_aw(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic             err_clr,
  output logic [DEPTH-1:0] load_en,
  output logic [AW-1:0]    rd_sel,
  output logic             push_ok,
  output logic             pop_ok,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             ovf,
  output logic             unf
);

  localparam logic [AW:0] COUNT_MAX = (AW + 1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          ovf_set;
  logic          unf_set;

  // Status comes from the count register only, so there is no path from push/pop to full/empty.
  assign full    = (count == COUNT_MAX);
  assign empty   = (count == '0);

  assign pop_ok  = pop & ~empty & ~flush;
  assign push_ok = push & ~flush & (~full | pop_ok);

  assign ovf_set = push & full & ~pop_ok & ~flush;
  assign unf_set = pop & empty & ~flush;

  assign rd_sel  = rd_ptr;

  always_comb begin
    load_en = '0;
    if (push_ok) begin
      load_en[wr_ptr] = 1'b1;
    end
  end

  cq_ptr #(.DEPTH(DEPTH), .AW(AW)) u_wr_ptr (
    .clk      (clk),
    .reset    (reset),
    .inc      (push_ok),
    .load     (1'b0),
    .load_val ('0),
    .ptr      (wr_ptr)
  );

  // Flush empties the queue by snapping the head onto the tail.
  cq_ptr #(.DEPTH(DEPTH), .AW(AW)) u_rd_ptr (
    .clk      (clk),
    .reset    (reset),
    .inc      (pop_ok),
    .load     (flush),
    .load_val (wr_ptr),
    .ptr      (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (push_ok && !pop_ok) begin
      count <= count + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count <= count - 1'b1;
    end
  end

  // A new error event in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (ovf_set)      ovf <= 1'b1;
      else if (err_clr) ovf <= 1'b0;
      if (unf_set)      unf <= 1'b1;
      else if (err_clr) unf <= 1'b0;
    end
  end

endmodule
